// File: rtl/mode_select_ctrl.sv
// Display mode sequencer: up/down/home buttons step a mode index with auto-repeat on long hold.
// Latency: one clock from a button level being high in IDLE to mode_o/mode_changed_o updating.
// Backpressure: none; presses arriving while a gesture is in progress are ignored until IDLE.
module mode_select_ctrl #(
  parameter int unsigned CLK_FREQ      = 12_000_000,
  parameter int unsigned NUM_MODES     = 8,
  parameter int unsigned HOLD_DELAY_MS = 500,
  parameter int unsigned REPEAT_MS     = 150,
  parameter bit          WRAP          = 1'b1,
  localparam int unsigned ModeWidth    = $clog2(NUM_MODES)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 btn_up_i,
  input  logic                 btn_down_i,
  input  logic                 btn_home_i,
  output logic [ModeWidth-1:0] mode_o,
  output logic                 mode_changed_o,
  output logic                 busy_o
);

  // Timing constants in clk_i cycles.
  localparam int unsigned HoldCycles   = (CLK_FREQ / 1000) * HOLD_DELAY_MS;
  localparam int unsigned RepeatCycles = (CLK_FREQ / 1000) * REPEAT_MS;
  localparam int unsigned MaxCycles    = (HoldCycles > RepeatCycles) ? HoldCycles : RepeatCycles;
  localparam int unsigned CntWidth     = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  // Terminal counts; a zero-length interval degenerates to "expire immediately".
  localparam logic [CntWidth-1:0] HoldLast   = CntWidth'((HoldCycles > 0) ? HoldCycles - 1 : 0);
  localparam logic [CntWidth-1:0] RepeatLast = CntWidth'((RepeatCycles > 0) ? RepeatCycles - 1 : 0);
  localparam logic [CntWidth-1:0] CntOne     = CntWidth'(1);

  localparam logic [ModeWidth-1:0] ModeMax = ModeWidth'(NUM_MODES - 1);
  localparam logic [ModeWidth-1:0] ModeOne = ModeWidth'(1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    HOLD_WAIT    = 2'd1,
    REPEAT       = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [ModeWidth-1:0]  mode_q, mode_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  dir_up_q, dir_up_d;   // 1: active button is up, 0: down
  logic                  changed_q, changed_d;
  logic                  busy_q, busy_d;

  logic [ModeWidth-1:0]  mode_inc;
  logic [ModeWidth-1:0]  mode_dec;
  logic [ModeWidth-1:0]  mode_step;
  logic                  active_btn;
  logic                  other_btn;
  logic                  any_btn;

  // Candidate next mode values for one step in each direction, honouring wrap/saturate.
  always_comb begin
    mode_inc = mode_q + ModeOne;
    mode_dec = mode_q - ModeOne;
    if (mode_q == ModeMax) begin
      mode_inc = WRAP ? '0 : ModeMax;
    end
    if (mode_q == '0) begin
      mode_dec = WRAP ? ModeMax : '0;
    end
    mode_step = dir_up_q ? mode_inc : mode_dec;
  end

  // Button qualification relative to the latched direction.
  always_comb begin
    active_btn = dir_up_q ? btn_up_i : btn_down_i;
    other_btn  = btn_home_i | (dir_up_q ? btn_down_i : btn_up_i);
    any_btn    = btn_up_i | btn_down_i | btn_home_i;
  end

  // Next-state, counter and mode update logic.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    dir_up_d = dir_up_q;

    unique case (state_q)
      IDLE: begin
        // Priority home > up > down when several rise together.
        if (btn_home_i) begin
          mode_d  = '0;
          cnt_d   = '0;
          state_d = WAIT_RELEASE;
        end else if (btn_up_i) begin
          mode_d   = mode_inc;
          dir_up_d = 1'b1;
          cnt_d    = '0;
          state_d  = HOLD_WAIT;
        end else if (btn_down_i) begin
          mode_d   = mode_dec;
          dir_up_d = 1'b0;
          cnt_d    = '0;
          state_d  = HOLD_WAIT;
        end
      end

      HOLD_WAIT: begin
        // Release wins over an expiring counter: no step on the release cycle.
        if (!active_btn) begin
          cnt_d   = '0;
          state_d = other_btn ? WAIT_RELEASE : IDLE;
        end else if (cnt_q == HoldLast) begin
          mode_d  = mode_step;
          cnt_d   = '0;
          state_d = REPEAT;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      REPEAT: begin
        if (!active_btn) begin
          cnt_d   = '0;
          state_d = other_btn ? WAIT_RELEASE : IDLE;
        end else if (cnt_q == RepeatLast) begin
          mode_d = mode_step;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      WAIT_RELEASE: begin
        // Everything must be released before a new gesture is accepted.
        if (!any_btn) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Strobe only on a real change, so saturated steps and home-at-zero stay silent.
  always_comb begin
    changed_d = (mode_d != mode_q);
    busy_d    = (state_d != IDLE);
  end

  // State and output registers; reset aborts any gesture immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      cnt_q     <= '0;
      dir_up_q  <= 1'b0;
      changed_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      dir_up_q  <= dir_up_d;
      changed_q <= changed_d;
      busy_q    <= busy_d;
    end
  end

  assign mode_o         = mode_q;
  assign mode_changed_o = changed_q;
  assign busy_o         = busy_q;

  // The index must never leave the legal range.
  a_mode_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    int'(mode_q) < int'(NUM_MODES));

  // busy mirrors the registered state.
  a_busy_matches_state: assert property (@(posedge clk_i) disable iff (!rst_ni)
    busy_q == (state_q != IDLE));

endmodule

// File: tb/tb_mode_select_ctrl.sv
module tb_mode_select_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       up_a = 1'b0, down_a = 1'b0, home_a = 1'b0;
  logic       up_b = 1'b0, down_b = 1'b0, home_b = 1'b0;
  logic [2:0] a_mode, b_mode;
  logic       a_chg, b_chg, a_busy, b_busy;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int strobes_a = 0;
  int strobes_b = 0;
  int cur_a = 0;
  int cur_b = 0;

  typedef struct {
    int mode;
    int edge_n;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mode_select_ctrl #(
    .CLK_FREQ(1000), .NUM_MODES(8), .HOLD_DELAY_MS(500), .REPEAT_MS(150), .WRAP(1'b1)
  ) u_dut_wrap (
    .clk_i(clk), .rst_ni(rst_n),
    .btn_up_i(up_a), .btn_down_i(down_a), .btn_home_i(home_a),
    .mode_o(a_mode), .mode_changed_o(a_chg), .busy_o(a_busy)
  );

  mode_select_ctrl #(
    .CLK_FREQ(1000), .NUM_MODES(8), .HOLD_DELAY_MS(500), .REPEAT_MS(150), .WRAP(1'b0)
  ) u_dut_sat (
    .clk_i(clk), .rst_ni(rst_n),
    .btn_up_i(up_b), .btn_down_i(down_b), .btn_home_i(home_b),
    .mode_o(b_mode), .mode_changed_o(b_chg), .busy_o(b_busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input bit on_b, input int mode, input int edge_n);
    exp_t e;
    e.mode = mode;
    e.edge_n = edge_n;
    if (on_b) q_b.push_back(e);
    else q_a.push_back(e);
  endtask

  // which: 0 = up, 1 = down, 2 = home
  task automatic set_btn(input bit on_b, input int which, input logic v);
    case ({on_b, 2'(which)})
      3'b000: up_a = v;
      3'b001: down_a = v;
      3'b010: home_a = v;
      3'b100: up_b = v;
      3'b101: down_b = v;
      default: home_b = v;
    endcase
  endtask

  // Short press (2 cycles high) with a hand-computed resulting mode.
  task automatic press(input bit on_b, input int which, input int exp_mode, input string tag);
    int prev;
    prev = on_b ? cur_b : cur_a;
    set_btn(on_b, which, 1'b1);
    if (exp_mode != prev) push_exp(on_b, exp_mode, cyc + 1);
    tick(2);
    set_btn(on_b, which, 1'b0);
    tick(2);
    chk(tag, on_b ? int'(b_mode) : int'(a_mode), exp_mode);
    chk({tag, "_busy"}, on_b ? int'(b_busy) : int'(a_busy), 0);
    if (on_b) cur_b = exp_mode;
    else cur_a = exp_mode;
  endtask

  // Scoreboard monitor: every strobe must match the next expected (mode, cycle).
  always @(negedge clk) begin
    if (rst_n && a_chg) begin
      strobes_a++;
      if (q_a.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL strobe_a_unexpected: got strobe with mode_o=%0d at cycle %0d, expected none", a_mode, cyc);
      end else begin
        mon_e = q_a.pop_front();
        chk("strobe_a_mode", int'(a_mode), mon_e.mode);
        chk("strobe_a_cycle", cyc, mon_e.edge_n);
      end
    end
    if (rst_n && b_chg) begin
      strobes_b++;
      if (q_b.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL strobe_b_unexpected: got strobe with mode_o=%0d at cycle %0d, expected none", b_mode, cyc);
      end else begin
        mon_e = q_b.pop_front();
        chk("strobe_b_mode", int'(b_mode), mon_e.mode);
        chk("strobe_b_cycle", cyc, mon_e.edge_n);
      end
    end
  end

  initial begin
    int n0;
    int s0;

    // Reset state
    tick(3);
    chk("rst_mode", int'(a_mode), 0);
    chk("rst_chg", int'(a_chg), 0);
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_mode_b", int'(b_mode), 0);
    rst_n = 1'b1;
    tick(1);

    // Single step: up held 3 cycles
    n0 = cyc;
    up_a = 1'b1;
    push_exp(1'b0, 1, n0 + 1);
    tick(1);
    chk("t1_mode", int'(a_mode), 1);
    chk("t1_busy", int'(a_busy), 1);
    tick(1);
    chk("t1_chg_one_cycle", int'(a_chg), 0);
    tick(1);
    up_a = 1'b0;
    tick(1);
    chk("t1_busy_release", int'(a_busy), 0);
    cur_a = 1;

    // Long hold from mode 0: steps at +1, +501, +651, +801, +951
    press(1'b0, 1, 0, "t2_down_to0");
    s0 = strobes_a;
    n0 = cyc;
    up_a = 1'b1;
    push_exp(1'b0, 1, n0 + 1);
    push_exp(1'b0, 2, n0 + 501);
    push_exp(1'b0, 3, n0 + 651);
    push_exp(1'b0, 4, n0 + 801);
    push_exp(1'b0, 5, n0 + 951);
    tick(1000);
    up_a = 1'b0;
    tick(1);
    chk("t2_final_mode", int'(a_mode), 5);
    chk("t2_strobe_count", strobes_a - s0, 5);
    chk("t2_busy", int'(a_busy), 0);
    cur_a = 5;

    // Wrap (instance A)
    press(1'b0, 0, 6, "t3_up6");
    press(1'b0, 0, 7, "t3_up7");
    press(1'b0, 0, 0, "t3_wrap_up");
    press(1'b0, 1, 7, "t3_wrap_down");

    // Saturation (instance B)
    press(1'b1, 1, 0, "t3_sat_down0");
    for (int i = 1; i <= 7; i++) press(1'b1, 0, i, "t3_b_up");
    s0 = strobes_b;
    press(1'b1, 0, 7, "t3_sat_up7");
    chk("t3_sat_no_strobe", strobes_b - s0, 0);

    // Simultaneous up+down, ignored home, release into WAIT_RELEASE
    press(1'b0, 1, 6, "t4_down6");
    press(1'b0, 1, 5, "t4_down5");
    press(1'b0, 1, 4, "t4_down4");
    press(1'b0, 1, 3, "t4_down3");
    n0 = cyc;
    up_a = 1'b1;
    down_a = 1'b1;
    push_exp(1'b0, 4, n0 + 1);
    tick(1);
    chk("t4_up_wins", int'(a_mode), 4);
    tick(9);
    home_a = 1'b1;
    tick(5);
    home_a = 1'b0;
    tick(5);
    chk("t4_home_ignored", int'(a_mode), 4);
    chk("t4_busy_hold", int'(a_busy), 1);
    up_a = 1'b0;
    tick(700);
    chk("t4_wait_release_mode", int'(a_mode), 4);
    chk("t4_wait_release_busy", int'(a_busy), 1);
    down_a = 1'b0;
    tick(2);
    chk("t4_idle_busy", int'(a_busy), 0);
    chk("t4_idle_mode", int'(a_mode), 4);
    cur_a = 4;

    // Home
    press(1'b0, 0, 5, "t5_up5");
    press(1'b0, 0, 6, "t5_up6");
    s0 = strobes_a;
    n0 = cyc;
    home_a = 1'b1;
    push_exp(1'b0, 0, n0 + 1);
    tick(1);
    chk("t5_home_mode", int'(a_mode), 0);
    chk("t5_home_busy", int'(a_busy), 1);
    tick(1999);
    chk("t5_home_held_mode", int'(a_mode), 0);
    chk("t5_home_strobes", strobes_a - s0, 1);
    home_a = 1'b0;
    tick(2);
    chk("t5_home_busy_release", int'(a_busy), 0);
    cur_a = 0;
    press(1'b0, 2, 0, "t5_home_at0");

    // Asynchronous reset in REPEAT at mode 4
    n0 = cyc;
    up_a = 1'b1;
    push_exp(1'b0, 1, n0 + 1);
    push_exp(1'b0, 2, n0 + 501);
    push_exp(1'b0, 3, n0 + 651);
    push_exp(1'b0, 4, n0 + 801);
    tick(850);
    chk("t6_repeat_mode", int'(a_mode), 4);
    chk("t6_repeat_busy", int'(a_busy), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_mode", int'(a_mode), 0);
    chk("t6_async_busy", int'(a_busy), 0);
    chk("t6_async_chg", int'(a_chg), 0);
    up_a = 1'b0;
    down_a = 1'b1;
    tick(2);
    rst_n = 1'b1;
    push_exp(1'b0, 7, cyc + 1);
    tick(1);
    chk("t6_down_after_reset", int'(a_mode), 7);
    down_a = 1'b0;
    tick(3);
    chk("t6_final_busy", int'(a_busy), 0);

    chk("queue_a_empty", q_a.size(), 0);
    chk("queue_b_empty", q_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mode_select_ctrl.md
Name: mode_select_ctrl

Overview:
- Sequencer sitting between the per-button debouncers and the VGA pattern/timing logic.
- Consumes three debounced button levels (up, down, home) and maintains the active display mode index.
- Provides single-step on press, auto-repeat on long hold, priority arbitration of simultaneous presses, and a one-cycle change strobe that downstream logic uses to reload its configuration.

Parameters:
- CLK_FREQ, 12_000_000: clk_i frequency in Hz.
- NUM_MODES, 8: number of selectable modes, legal range 2..256.
- HOLD_DELAY_MS, 500: hold time after the first step before auto-repeat starts.
- REPEAT_MS, 150: auto-repeat step period.
- WRAP, 1: 1 = wrap at the ends; 0 = saturate at the ends.
- Derived: ModeWidth = $clog2(NUM_MODES); HoldCycles = (CLK_FREQ/1000)*HOLD_DELAY_MS; RepeatCycles = (CLK_FREQ/1000)*REPEAT_MS. Counter width is sized for the larger of HoldCycles and RepeatCycles.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- btn_up_i  input  1  debounced level, synchronous to clk_i
- btn_down_i  input  1  debounced level, synchronous to clk_i
- btn_home_i  input  1  debounced level, synchronous to clk_i
- mode_o  output  ModeWidth  current mode index
- mode_changed_o  output  1  one-cycle strobe, high in the cycle mode_o first shows a new value
- busy_o  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_ni). On reset, FSM = IDLE, mode_o = 0, mode_changed_o = 0, busy_o = 0, counter = 0. Asserting reset mid-hold or mid-repeat aborts immediately. After release, a still-held button is treated as a new press.
- All outputs are registered.
- States: IDLE, HOLD_WAIT, REPEAT, WAIT_RELEASE.
- IDLE:
  - Any button high at a clock edge → apply action at that edge.
  - mode_o and mode_changed_o update on the same edge, so latency is one cycle from the input being high to the output changing.
  - Priority when several buttons are high together: home > up > down.
  - Home: mode ← 0, go to WAIT_RELEASE. No repeat for home.
  - Up/down: step once, latch the active direction, clear the counter, go to HOLD_WAIT.
- HOLD_WAIT:
  - Counter increments each cycle while the active button is high.
  - When counter == HoldCycles-1: step again, clear the counter, go to REPEAT.
- REPEAT:
  - Counter increments each cycle.
  - When counter == RepeatCycles-1: step, clear the counter, stay in REPEAT.
- Release in HOLD_WAIT or REPEAT (active button low):
  - If any other button is high → WAIT_RELEASE.
  - Otherwise → IDLE.
  - Counter cleared in both cases. No step occurs on the release cycle, even if the counter would have expired.
- New presses while not in IDLE: all other buttons are ignored, including home. No action is taken until the FSM is back in IDLE.
- WAIT_RELEASE: go to IDLE on the first cycle in which all three buttons are low.
- Step arithmetic:
  - Up: mode+1. At NUM_MODES-1, WRAP=1 gives 0; WRAP=0 holds at NUM_MODES-1.
  - Down: mode-1. At 0, WRAP=1 gives NUM_MODES-1; WRAP=0 holds at 0.
  - mode_o never takes a value ≥ NUM_MODES.
- mode_changed_o is asserted only when the new value differs from the old one. A saturated step or a home press at mode 0 produces no strobe.
- busy_o = (state != IDLE), registered with the state.

Test Plan (CLK_FREQ=1000, so 1 cycle/ms; HOLD_DELAY_MS=500, REPEAT_MS=150, NUM_MODES=8):
1. Reset, then hold btn_up_i high for 3 cycles → mode_o = 1 one cycle after the rise; mode_changed_o high for exactly 1 cycle; busy_o returns to 0 one cycle after release.
2. Hold btn_up_i for 1000 cycles from mode 0:
   - steps at cycles 1, 501, 651, 801, 951;
   - final mode_o = 5; five strobes in total.
3. Wrap and saturation:
   - WRAP=1, mode 7, one up press → 0; then one down press → 7.
   - WRAP=0, mode 7, up press → stays 7 and no mode_changed_o.
4. btn_up_i and btn_down_i rise on the same cycle at mode 3 → mode 4 (up wins). Raise btn_home_i mid-hold → ignored. Drop up while down is still high → WAIT_RELEASE, no further steps until all buttons are low.
5. btn_home_i at mode 6 → mode_o = 0 with a strobe. Holding home for 2000 cycles → no further strobes.
6. Assert rst_ni low asynchronously in REPEAT at mode 4 → mode_o = 0 and busy_o = 0 immediately, without waiting for a clock edge. After release with btn_down_i still high → mode_o = 7 on the next edge.
